fp_addsub_pipe: RTL

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor for the FPU datapath. It generalises the single-precision add path to arbitrary exponent and mantissa widths. The datapath is a 3-stage pipeline (align, add, normalise/round) with round-to-nearest-even. A valid/ready handshake with full backpressure lets it sit between the operand issue logic and the FPU result bus.

---
 rtl/fp_addsub_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// fp_addsub_pipe : 3-stage pipelined floating-point add/sub (RNE, FTZ) with
//                  valid/ready handshake and full backpressure.
// Revision       : 1.0
// ============================================================================
module fp_addsub_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         add_sub,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic [3:0]   flags
);

  localparam int c_sig_w = MAN_W + 3;
  localparam int c_sum_w = MAN_W + 5;
  localparam int c_sh_w  = $clog2(c_sig_w + 1);
  localparam int c_x_w   = EXP_W + c_sh_w + 2;
  localparam logic signed [c_x_w-1:0] c_emax = c_x_w'((1 << EXP_W) - 1);

  logic w_advance;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------- stage 1: classify, swap, align ----------------
  logic                 w_sa, w_sb;
  logic [EXP_W-1:0]     w_ea, w_eb, w_big_e, w_sml_e, w_diff;
  logic [MAN_W-1:0]     w_fa, w_fb, w_big_f, w_sml_f;
  logic                 w_big_s, w_sml_s, w_swap;
  logic                 w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [c_sh_w-1:0]    w_shamt;
  logic [2*c_sig_w-1:0] w_shifted;
  logic                 w_spec;
  logic [W-1:0]         w_spec_val;
  logic [3:0]           w_spec_flg;

  assign w_sa = opa[W-1];
  assign w_ea = opa[W-2:MAN_W];
  assign w_fa = opa[MAN_W-1:0];
  assign w_sb = opb[W-1] ^ ~add_sub;
  assign w_eb = opb[W-2:MAN_W];
  assign w_fb = opb[MAN_W-1:0];

  always_comb begin
    w_a_zero = (w_ea == '0);
    w_b_zero = (w_eb == '0);
    w_a_nan  = (&w_ea) & (|w_fa);
    w_b_nan  = (&w_eb) & (|w_fb);
    w_a_inf  = (&w_ea) & ~(|w_fa);
    w_b_inf  = (&w_eb) & ~(|w_fb);
    w_swap   = {w_eb, w_fb} > {w_ea, w_fa};
    w_big_s  = w_swap ? w_sb : w_sa;
    w_sml_s  = w_swap ? w_sa : w_sb;
    w_big_e  = w_swap ? w_eb : w_ea;
    w_sml_e  = w_swap ? w_ea : w_eb;
    w_big_f  = w_swap ? w_fb : w_fa;
    w_sml_f  = w_swap ? w_fa : w_fb;
    w_diff   = w_big_e - w_sml_e;
    if ({{(32-EXP_W){1'b0}}, w_diff} >= c_sig_w)
      w_shamt = c_sh_w'(c_sig_w);
    else
      w_shamt = w_diff[c_sh_w-1:0];
    // Low half collects every bit shifted past R; it becomes the sticky bit.
    w_shifted = {1'b1, w_sml_f, 2'b00, {c_sig_w{1'b0}}} >> w_shamt;

    w_spec     = 1'b1;
    w_spec_flg = 4'b0000;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb))) begin
      w_spec_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_spec_flg = 4'b1000;
    end else if (w_a_inf)
      w_spec_val = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_b_inf)
      w_spec_val = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (w_a_zero & w_b_zero)
      w_spec_val = {w_sa & w_sb, {(W-1){1'b0}}};
    else if (w_a_zero)
      w_spec_val = {w_sb, w_eb, w_fb};
    else if (w_b_zero)
      w_spec_val = opa;
    else begin
      w_spec     = 1'b0;
      w_spec_val = '0;
    end
  end

  logic               s1_valid_q, s1_spec_q, s1_sign_q, s1_sub_q, s1_sticky_q;
  logic [W-1:0]       s1_spec_val_q;
  logic [3:0]         s1_spec_flg_q;
  logic [EXP_W-1:0]   s1_exp_q;
  logic [c_sig_w-1:0] s1_big_q, s1_sml_q;

  // ---------------- stage 2: magnitude add / subtract ----------------
  logic [c_sum_w-1:0] w_opa_ext, w_opb_ext, w_raw;
  assign w_opa_ext = {1'b0, s1_big_q, 1'b0};
  assign w_opb_ext = {1'b0, s1_sml_q, s1_sticky_q};
  assign w_raw     = s1_sub_q ? (w_opa_ext - w_opb_ext) : (w_opa_ext + w_opb_ext);

  logic               s2_valid_q, s2_spec_q, s2_sign_q;
  logic [W-1:0]       s2_spec_val_q;
  logic [3:0]         s2_spec_flg_q;
  logic [EXP_W-1:0]   s2_exp_q;
  logic [c_sum_w-1:0] s2_raw_q;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [c_sh_w-1:0]        w_lz;
  logic [c_sum_w-2:0]       w_norm;
  logic signed [c_x_w-1:0]  w_exp_x, w_exp_n, w_exp_r;
  logic                     w_up;
  logic [MAN_W+1:0]         w_rnd;
  logic [W-1:0]             sum_d;
  logic [3:0]               flags_d;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < c_sum_w - 1; i++)
      if (s2_raw_q[i]) w_lz = c_sh_w'(c_sum_w - 2 - i);
    w_exp_x = $signed({{(c_x_w-EXP_W){1'b0}}, s2_exp_q});
    if (s2_raw_q[c_sum_w-1]) begin
      w_norm  = {s2_raw_q[c_sum_w-1:2], |s2_raw_q[1:0]};
      w_exp_n = w_exp_x + c_x_w'(1);
    end else begin
      w_norm  = s2_raw_q[c_sum_w-2:0] << w_lz;
      w_exp_n = w_exp_x - $signed({{(c_x_w-c_sh_w){1'b0}}, w_lz});
    end
    w_up    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd   = {1'b0, w_norm[c_sum_w-2:3]} + {{(MAN_W+1){1'b0}}, w_up};
    w_exp_r = w_exp_n + {{(c_x_w-1){1'b0}}, w_rnd[MAN_W+1]};

    if (s2_spec_q) begin
      sum_d   = s2_spec_val_q;
      flags_d = s2_spec_flg_q;
    end else if (s2_raw_q == '0) begin
      sum_d   = '0;
      flags_d = 4'b0000;
    end else if (w_exp_n[c_x_w-1] || (w_exp_n == '0)) begin
      sum_d   = {s2_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (w_exp_r >= c_emax) begin
      sum_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else begin
      sum_d   = {s2_sign_q, w_exp_r[EXP_W-1:0], w_rnd[MAN_W-1:0]};
      flags_d = {3'b000, |w_norm[2:0]};
    end
  end

  logic         out_valid_q;
  logic [W-1:0] sum_q;
  logic [3:0]   flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0; s1_spec_q <= 1'b0; s1_sign_q <= 1'b0; s1_sub_q <= 1'b0;
      s1_sticky_q <= 1'b0; s1_spec_val_q <= '0; s1_spec_flg_q <= '0;
      s1_exp_q <= '0; s1_big_q <= '0; s1_sml_q <= '0;
      s2_valid_q <= 1'b0; s2_spec_q <= 1'b0; s2_sign_q <= 1'b0;
      s2_spec_val_q <= '0; s2_spec_flg_q <= '0; s2_exp_q <= '0; s2_raw_q <= '0;
      out_valid_q <= 1'b0; sum_q <= '0; flags_q <= '0;
    end else if (w_advance) begin
      s1_valid_q    <= in_valid;
      s1_spec_q     <= w_spec;
      s1_spec_val_q <= w_spec_val;
      s1_spec_flg_q <= w_spec_flg;
      s1_sign_q     <= w_big_s;
      s1_sub_q      <= w_big_s ^ w_sml_s;
      s1_exp_q      <= w_big_e;
      s1_big_q      <= {1'b1, w_big_f, 2'b00};
      s1_sml_q      <= w_shifted[2*c_sig_w-1:c_sig_w];
      s1_sticky_q   <= |w_shifted[c_sig_w-1:0];
      s2_valid_q    <= s1_valid_q;
      s2_spec_q     <= s1_spec_q;
      s2_spec_val_q <= s1_spec_val_q;
      s2_spec_flg_q <= s1_spec_flg_q;
      s2_sign_q     <= s1_sign_q;
      s2_exp_q      <= s1_exp_q;
      s2_raw_q      <= w_raw;
      out_valid_q   <= s2_valid_q;
      if (s2_valid_q) begin
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire
